// File: rtl/fortaegis_report_tx.sv
// fortaegis_report_tx: captures one frame plus the top-3 histogram result,
// then streams them out as a single byte packet with a valid/ready handshake.
// Packet layout: 0xA5, six top-3 bytes, LENGTH/2 packed frame bytes, and an
// optional modulo-256 checksum byte.
// Build option: FORTAEGIS_REPORT_CHECKSUM_EN adds the trailing checksum byte.
//
// state   | meaning
// S_IDLE  | accepting frame writes and top-3 strobe, waiting for both
// S_HDR   | sending header byte 0xA5
// S_TOP   | sending six top-3 bytes (bin, count) x3
// S_FRAME | sending packed frame bytes, two entries per byte
// S_CSUM  | sending checksum byte (checksum build only)
module fortaegis_report_tx #(
  parameter int DATA_SIZE   = 4,
  parameter int LENGTH      = 64,
  parameter int LENGTH_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   FramEn,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic                   SortValid,
  input  logic [DATA_SIZE-1:0]   MaxCountData1,
  input  logic [DATA_SIZE-1:0]   MaxCountData2,
  input  logic [DATA_SIZE-1:0]   MaxCountData3,
  input  logic [LENGTH_SIZE-1:0] MaxCount1,
  input  logic [LENGTH_SIZE-1:0] MaxCount2,
  input  logic [LENGTH_SIZE-1:0] MaxCount3,
  output logic [7:0]             TxData,
  output logic                   TxValid,
  input  logic                   TxReady,
  output logic                   TxLast,
  output logic                   Busy,
  output logic                   Overrun
);

  localparam int NFB = LENGTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TOP,
    S_FRAME
`ifdef FORTAEGIS_REPORT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [LENGTH_SIZE-1:0] idx, idx_nxt;
  logic [DATA_SIZE-1:0]   mem [LENGTH];
  logic                   frame_rdy, sort_rdy, overrun_q;
  logic [DATA_SIZE-1:0]   top_data1, top_data2, top_data3;
  logic [LENGTH_SIZE-1:0] top_cnt1, top_cnt2, top_cnt3;
  logic [LENGTH_SIZE-1:0] addr_even, addr_odd;
  logic                   start;
`ifdef FORTAEGIS_REPORT_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  assign Busy      = (state != S_IDLE);
  assign Overrun   = overrun_q;
  assign start     = frame_rdy && sort_rdy;
  assign addr_even = {idx[LENGTH_SIZE-2:0], 1'b0};
  assign addr_odd  = {idx[LENGTH_SIZE-2:0], 1'b1};

  // State and byte-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state and output decode; outputs depend only on registered state so
  // they hold steady while the sink stalls.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    TxValid   = 1'b0;
    TxLast    = 1'b0;
    TxData    = 8'h00;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_HDR;
          idx_nxt   = '0;
        end
      end
      S_HDR: begin
        TxValid = 1'b1;
        TxData  = 8'hA5;
        if (TxReady) begin
          state_nxt = S_TOP;
          idx_nxt   = '0;
        end
      end
      S_TOP: begin
        TxValid = 1'b1;
        case (idx[2:0])
          3'd0:    TxData = 8'(top_data1);
          3'd1:    TxData = 8'(top_cnt1);
          3'd2:    TxData = 8'(top_data2);
          3'd3:    TxData = 8'(top_cnt2);
          3'd4:    TxData = 8'(top_data3);
          default: TxData = 8'(top_cnt3);
        endcase
        if (TxReady) begin
          if (idx[2:0] == 3'd5) begin
            state_nxt = S_FRAME;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_FRAME: begin
        TxValid = 1'b1;
        TxData  = {mem[addr_odd], mem[addr_even]};
        if (idx == LENGTH_SIZE'(NFB - 1)) begin
`ifdef FORTAEGIS_REPORT_CHECKSUM_EN
          if (TxReady) state_nxt = S_CSUM;
`else
          TxLast = 1'b1;
          if (TxReady) state_nxt = S_IDLE;
`endif
        end else if (TxReady) begin
          idx_nxt = idx + 1'b1;
        end
      end
`ifdef FORTAEGIS_REPORT_CHECKSUM_EN
      S_CSUM: begin
        TxValid = 1'b1;
        TxLast  = 1'b1;
        TxData  = csum;
        if (TxReady) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture flags, registered top-3 values and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_rdy <= 1'b0;
      sort_rdy  <= 1'b0;
      overrun_q <= 1'b0;
      top_data1 <= '0;
      top_data2 <= '0;
      top_data3 <= '0;
      top_cnt1  <= '0;
      top_cnt2  <= '0;
      top_cnt3  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        frame_rdy <= 1'b0;
        sort_rdy  <= 1'b0;
      end else begin
        if (FramEn && !Busy && FramAdd == LENGTH_SIZE'(LENGTH - 1)) frame_rdy <= 1'b1;
        if (SortValid && !Busy) sort_rdy <= 1'b1;
      end
      if (SortValid && !Busy) begin
        top_data1 <= MaxCountData1;
        top_data2 <= MaxCountData2;
        top_data3 <= MaxCountData3;
        top_cnt1  <= MaxCount1;
        top_cnt2  <= MaxCount2;
        top_cnt3  <= MaxCount3;
      end
      if (Busy && (FramEn || SortValid)) overrun_q <= 1'b1;
    end
  end

  // Frame buffer; contents survive reset and packets, only writes change it.
  always_ff @(posedge clk) begin
    if (FramEn && !Busy) mem[FramAdd] <= FramData;
  end

`ifdef FORTAEGIS_REPORT_CHECKSUM_EN
  // Running sum of every byte accepted in the current packet.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) csum <= 8'h00;
    else if (TxValid && TxReady) csum <= csum + TxData;
  end
`endif

endmodule

// File: doc/fortaegis_report_tx.md
FORTAEGIS_REPORT_TX -- requirements
Module: fortaegis_report_tx

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, frame sample width; only value 4 is supported.
REQ-002 SHALL have parameter LENGTH, default 64, frame entries per capture; must be even.
REQ-003 SHALL have parameter LENGTH_SIZE, default 6, frame address width (log2 LENGTH).
REQ-004 SHALL have ports (clock and reset first), name / direction / width / meaning:
- clk  in  1  sole clock; one clock only.
- rst  in  1  reset, synchronous and active-high.
- FramEn  in  1  frame entry write strobe.
- FramAdd  in  LENGTH_SIZE  frame entry index.
- FramData  in  DATA_SIZE  frame entry value.
- SortValid  in  1  one-cycle strobe; top-3 inputs are valid this cycle.
- MaxCountData1/2/3  in  DATA_SIZE  top-3 histogram bins.
- MaxCount1/2/3  in  LENGTH_SIZE  top-3 counts.
- TxData  out  8  packet byte.
- TxValid  out  1  TxData is valid.
- TxReady  in  1  sink accepts the byte when TxValid&&TxReady.
- TxLast  out  1  marks the final byte of a packet.
- Busy  out  1  a packet is being assembled or sent.
- Overrun  out  1  sticky flag; input was dropped while Busy.

Function
REQ-005 SHALL hold a LENGTH x DATA_SIZE frame buffer; when FramEn && !Busy, write FramData to entry FramAdd.
REQ-006 SHALL set FrameRdy on an accepted write with FramAdd==LENGTH-1.
REQ-007 SHALL register all six top-3 values and set SortRdy on SortValid && !Busy.
- FrameRdy and SortRdy may arrive in either order or in the same cycle.
REQ-008 SHALL leave IDLE for HDR the cycle after both FrameRdy and SortRdy are set.
- Busy=1 from that cycle until TxLast is accepted.
- FrameRdy and SortRdy clear on entry to HDR.
REQ-009 SHALL step through states IDLE -> HDR -> TOP -> FRAME -> CSUM -> IDLE.
- Each state advances only on an accepted byte.
REQ-010 SHALL send these bytes in order:
- HDR: 0xA5.
- TOP: six bytes, {0, MaxCountDataN} then {0, MaxCountN}, N=1,2,3, each zero-extended to 8 bits.
- FRAME: LENGTH/2 bytes; byte k = {entry[2k+1], entry[2k]}.
- CSUM: 8-bit modulo-256 sum of all preceding bytes of the packet, including HDR.
REQ-011 SHALL keep TxData and TxLast stable while TxValid && !TxReady.
REQ-012 SHALL sustain one byte per cycle while TxReady stays high; TxValid stays 1 from HDR until the last byte is accepted.
REQ-013 SHALL assert TxLast only on the final byte of the packet.
REQ-014 SHALL ignore FramEn and SortValid when Busy, and set Overrun when either occurs while Busy.
- Overrun clears only on rst.
REQ-015 SHALL keep the byte counter in range 0..LENGTH/2-1 during FRAME, with no wrap past the final frame byte.
REQ-016 SHALL allow a new capture to start the cycle after TxLast is accepted; the frame buffer is not cleared.

Reset
REQ-017 SHALL, when rst=1 at a clock edge, force state IDLE and clear FrameRdy, SortRdy and Overrun.
- TxValid=0, TxLast=0, TxData=0x00, Busy=0.
- Registered top-3 values go to 0; frame buffer contents are don't-care.
REQ-018 SHALL, when rst is asserted mid-packet, abort the packet without emitting TxLast.

Configuration
REQ-019 SHALL compile in the CSUM state only when macro FORTAEGIS_REPORT_CHECKSUM_EN is defined.
- Defined: packet = 1+6+LENGTH/2+1 bytes (40 at defaults); TxLast on the checksum byte.
- Undefined: the CSUM state is absent; packet = 39 bytes at defaults; TxLast on frame byte LENGTH/2-1; FRAME returns directly to IDLE.

Verification
REQ-020 SHALL cover, with defaults and the macro defined:
- Zero packet: all 64 entries = 0, top-3 all 0, TxReady=1 -> A5, 38x 00, A5 with TxLast; 40 consecutive cycles.
- Ramp packet: entry[i] = i[3:0]; top (5,20),(3,10),(9,4) -> bytes A5 05 14 03 0A 09 04, then 10 32 54 76 98 BA DC FE repeated 4x, then the 8-bit sum.
- Backpressure: TxReady toggles 1/0 every cycle -> same byte sequence; TxData is unchanged across each stall.
- Order: SortValid 10 cycles before the frame's last write, then SortValid in the same cycle as the last write -> each starts HDR exactly one cycle after the later event.
- Overrun: FramEn while Busy -> buffer unchanged, Overrun=1 until rst.
- Reset mid-FRAME at byte 12 -> TxValid=0 next cycle, no TxLast, next packet starts with A5.
